// File: rtl/lw_sha_pkg.sv
// Shared definitions for the lightweight SHA/HMAC host and engine wrapper.
// CORE_ARCH_S64 widens data/key/digest words to 64 bits.
package lw_sha_pkg;

`ifdef CORE_ARCH_S64
    localparam int LW_WORD_W = 64;
`else
    localparam int LW_WORD_W = 32;
`endif

    localparam int KEY_WORDS    = 16;
    localparam int DIGEST_WORDS = 8;
    localparam int HMAC_OP_BIT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_KEY,
        ST_MSG,
        ST_WAIT,
        ST_DRAIN,
        ST_ABORT
    } host_state_e;

    function automatic logic is_hmac(input logic [3:0] opcode);
        return opcode[HMAC_OP_BIT];
    endfunction

endpackage

// File: rtl/lw_hmac_host_dig_buf.sv
// Digest capture register: loads all words at once, then serialises them
// lowest index first on a valid/ready stream with a last flag.
module lw_hmac_host_dig_buf
    import lw_sha_pkg::*;
#(
    parameter int WORD_W = LW_WORD_W,
    parameter int DEPTH  = DIGEST_WORDS
) (
    input  logic                          clk_i,
    input  logic                          aresetn_i,
    input  logic                          load,
    input  logic [DEPTH-1:0][WORD_W-1:0]  hash,
    output logic                          valid,
    input  logic                          ready,
    output logic [WORD_W-1:0]             data,
    output logic                          last
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WORD_W-1:0] words_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         valid_q;
    logic                         at_end;

    assign at_end = (idx_q == IDX_W'(DEPTH - 1));

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            // NOTE: the digest storage is cleared too, so a read before the
            // first capture returns zeros instead of X.
            words_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            // NOTE: state updates use <= so every register samples the
            // pre-edge values, independent of statement order.
            words_q <= hash;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            if (at_end) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign valid = valid_q;
    assign data  = valid_q ? words_q[idx_q] : '0;
    assign last  = valid_q && at_end;

endmodule

// File: rtl/lw_hmac_host.sv
// Host-side initiator for the lightweight SHA/HMAC engine.
// Optional watchdog: define LW_HOST_TIMEOUT_EN.
module lw_hmac_host
    import lw_sha_pkg::*;
#(
    parameter int WORD_W = LW_WORD_W
`ifdef LW_HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                               clk_i,
    input  logic                               aresetn_i,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic [3:0]                         cmd_opcode_i,
    input  logic                               key_wr_i,
    input  logic [3:0]                         key_idx_i,
    input  logic [WORD_W-1:0]                  key_data_i,
    input  logic                               msg_valid_i,
    output logic                               msg_ready_o,
    input  logic [WORD_W-1:0]                  msg_data_i,
    input  logic                               msg_last_i,
    output logic                               eng_start_o,
    output logic                               eng_abort_o,
    output logic                               eng_data_valid_o,
    output logic                               eng_last_o,
    output logic [WORD_W-1:0]                  eng_data_o,
    output logic [3:0]                         eng_opcode_o,
    output logic [WORD_W-1:0]                  eng_key_o,
    output logic                               eng_key_valid_o,
    input  logic                               eng_key_ready_i,
    input  logic                               eng_ready_i,
    input  logic                               eng_done_i,
    input  logic [DIGEST_WORDS-1:0][WORD_W-1:0] eng_hash_i,
    output logic                               dig_valid_o,
    input  logic                               dig_ready_i,
    output logic [WORD_W-1:0]                  dig_data_o,
    output logic                               dig_last_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int KIDX_W = $clog2(KEY_WORDS);

    host_state_e       state;
    logic [3:0]        opcode_q;
    logic [KIDX_W-1:0] key_idx_q;
    logic              err_q;
    logic              cmd_ready_q;
    logic [WORD_W-1:0] key_reg [KEY_WORDS];

    logic in_key, in_msg;
    logic cmd_fire, key_fire, msg_fire, dig_fire;
    logic dig_load;

    assign in_key   = (state == ST_KEY);
    assign in_msg   = (state == ST_MSG);
    assign cmd_fire = cmd_valid_i && cmd_ready_q;
    assign key_fire = in_key && eng_key_ready_i;
    assign msg_fire = in_msg && msg_valid_i && eng_ready_i;
    assign dig_fire = dig_valid_o && dig_ready_i;
    assign dig_load = (state == ST_WAIT) && eng_done_i;

    // Key file is writable only between operations.
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            for (int i = 0; i < KEY_WORDS; i++) key_reg[i] <= '0;
        end else if (key_wr_i && state == ST_IDLE) begin
            key_reg[key_idx_i] <= key_data_i;
        end
    end

`ifdef LW_HOST_TIMEOUT_EN
    logic [15:0] wd_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            state       <= ST_IDLE;
            opcode_q    <= '0;
            key_idx_q   <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef LW_HOST_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        opcode_q    <= cmd_opcode_i;
                        err_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    key_idx_q <= KIDX_W'(KEY_WORDS - 1);
                    state     <= is_hmac(opcode_q) ? ST_KEY : ST_MSG;
                end
                ST_KEY: begin
                    if (eng_done_i) begin
                        state <= ST_ABORT;
                    end else if (key_fire) begin
                        if (key_idx_q == '0) state <= ST_MSG;
                        else                 key_idx_q <= key_idx_q - 1'b1;
                    end
                end
                ST_MSG: begin
                    if (eng_done_i)                state <= ST_ABORT;
                    else if (msg_fire && msg_last_i) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Ready rises only once IDLE is reached, so a command
                    // waiting during the final digest word is taken a cycle later.
                    if (dig_fire && dig_last_o) begin
                        state       <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ABORT: begin
                    err_q       <= 1'b1;
                    cmd_ready_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

`ifdef LW_HOST_TIMEOUT_EN
            // Later assignment to state overrides the case above on expiry.
            if (in_key || in_msg || state == ST_WAIT) begin
                if (key_fire || msg_fire || eng_done_i) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    wd_cnt <= '0;
                    state  <= ST_ABORT;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign busy_o           = (state != ST_IDLE);
    assign err_o            = err_q;
    assign eng_start_o      = (state == ST_START);
    assign eng_abort_o      = (state == ST_ABORT);
    assign eng_opcode_o     = opcode_q;
    assign eng_key_valid_o  = in_key;
    assign eng_key_o        = in_key ? key_reg[key_idx_q] : '0;

    // Message words pass straight through to the engine with zero latency.
    assign eng_data_valid_o = eng_start_o || (in_msg && msg_valid_i);
    assign eng_data_o       = in_msg ? msg_data_i : '0;
    assign eng_last_o       = in_msg && msg_last_i;
    assign msg_ready_o      = in_msg && eng_ready_i;

    lw_hmac_host_dig_buf #(
        .WORD_W (WORD_W),
        .DEPTH  (DIGEST_WORDS)
    ) u_dig_buf (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .load      (dig_load),
        .hash      (eng_hash_i),
        .valid     (dig_valid_o),
        .ready     (dig_ready_i),
        .data      (dig_data_o),
        .last      (dig_last_o)
    );

endmodule

// File: tb/tb_lw_hmac_host.sv
// Self-checking bench for lw_hmac_host: table of operations plus random ones,
// with hand-written abort and reset sequences.
module tb_lw_hmac_host;
    import lw_sha_pkg::*;

    localparam int W   = LW_WORD_W;
    localparam int TMO = 2000;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                          aresetn_i;
    logic                          cmd_valid_i, cmd_ready_o;
    logic [3:0]                    cmd_opcode_i;
    logic                          key_wr_i;
    logic [3:0]                    key_idx_i;
    logic [W-1:0]                  key_data_i;
    logic                          msg_valid_i, msg_ready_o, msg_last_i;
    logic [W-1:0]                  msg_data_i;
    logic                          eng_start_o, eng_abort_o, eng_data_valid_o, eng_last_o;
    logic [W-1:0]                  eng_data_o, eng_key_o;
    logic [3:0]                    eng_opcode_o;
    logic                          eng_key_valid_o, eng_key_ready_i;
    logic                          eng_ready_i, eng_done_i;
    logic [DIGEST_WORDS-1:0][W-1:0] eng_hash_i;
    logic                          dig_valid_o, dig_ready_i, dig_last_o;
    logic [W-1:0]                  dig_data_o;
    logic                          busy_o, err_o;

    lw_hmac_host dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_opcode_i(cmd_opcode_i),
        .key_wr_i(key_wr_i), .key_idx_i(key_idx_i), .key_data_i(key_data_i),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .msg_data_i(msg_data_i), .msg_last_i(msg_last_i),
        .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o),
        .eng_data_valid_o(eng_data_valid_o), .eng_last_o(eng_last_o),
        .eng_data_o(eng_data_o), .eng_opcode_o(eng_opcode_o),
        .eng_key_o(eng_key_o), .eng_key_valid_o(eng_key_valid_o), .eng_key_ready_i(eng_key_ready_i),
        .eng_ready_i(eng_ready_i), .eng_done_i(eng_done_i), .eng_hash_i(eng_hash_i),
        .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready_i),
        .dig_data_o(dig_data_o), .dig_last_o(dig_last_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] key_model [KEY_WORDS];

    typedef struct {
        logic [3:0] op;
        int         nwords;
        bit         stall;
        bit         hold;
        bit         new_key;
        int         exp_keys;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return W'(r);
    endfunction

    task automatic program_key(input bit random_key);
        for (int i = 0; i < KEY_WORDS; i++) begin
            @(negedge clk_i);
            key_wr_i     = 1'b1;
            key_idx_i    = 4'(i);
            key_data_i   = random_key ? rnd_word() : W'(i);
            key_model[i] = key_data_i;
        end
        @(negedge clk_i);
        key_wr_i = 1'b0;
    endtask

    // One full operation: command, optional key stream, message, digest drain.
    task automatic do_op(input logic [3:0] op, input int nwords, input bit stall,
                         input bit hold, output int nkeys);
        logic [W-1:0] msg_q [$];
        logic [DIGEST_WORDS-1:0][W-1:0] hash;
        int cyc, sent, got, stall_left, nwait;
        bit stalled, pend;

        @(negedge clk_i);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        #1;
        check("cmd_ready", 64'(cmd_ready_o), 64'(1));
        @(negedge clk_i);
        cmd_valid_i  = 1'b0;
        cmd_opcode_i = 4'($urandom());
        #1;
        check("start", 64'({eng_start_o, eng_data_valid_o, eng_opcode_o, err_o, busy_o}),
              64'({1'b1, 1'b1, op, 1'b0, 1'b1}));

        nkeys = 0;
        cyc   = 0;
        if (op[3]) begin
            while (nkeys < KEY_WORDS && cyc < TMO) begin
                @(negedge clk_i);
                eng_key_ready_i = ($urandom_range(0, 3) != 0);
                eng_ready_i     = $urandom_range(0, 1) != 0;
                #1;
                cyc++;
                check("key_no_msg", 64'({eng_data_valid_o, msg_ready_o, eng_key_valid_o}), 64'(3'b001));
                if (eng_key_valid_o && eng_key_ready_i) begin
                    check("key_word", 64'(eng_key_o), 64'(key_model[KEY_WORDS - 1 - nkeys]));
                    nkeys++;
                end
            end
        end

        for (int i = 0; i < nwords; i++) msg_q.push_back(rnd_word());
        sent = 0;
        cyc  = 0;
        while (sent < nwords && cyc < TMO) begin
            @(negedge clk_i);
            eng_key_ready_i = 1'b0;
            msg_valid_i = ($urandom_range(0, 3) != 0);
            msg_data_i  = msg_q[sent];
            msg_last_i  = (sent == nwords - 1);
            eng_ready_i = ($urandom_range(0, 3) != 0);
            key_wr_i    = (cyc == 0);
            key_idx_i   = 4'd5;
            key_data_i  = ~key_model[5];
            #1;
            cyc++;
            check("msg_pass", 64'({eng_data_valid_o, msg_ready_o, eng_last_o, eng_key_valid_o}),
                  64'({msg_valid_i, eng_ready_i, msg_last_i, 1'b0}));
            if (msg_valid_i && msg_ready_o) begin
                check("msg_data", 64'(eng_data_o), 64'(msg_q[sent]));
                sent++;
            end
        end
        if (sent != nwords) check("msg_timeout", 64'(sent), 64'(nwords));

        nwait = $urandom_range(1, 4);
        for (int j = 0; j < nwait; j++) begin
            @(negedge clk_i);
            msg_valid_i = 1'b0;
            msg_last_i  = 1'b0;
            key_wr_i    = 1'b0;
            eng_ready_i = $urandom_range(0, 1) != 0;
            #1;
            check("wait", 64'({dig_valid_o, busy_o, eng_data_valid_o}), 64'(3'b010));
        end

        for (int i = 0; i < DIGEST_WORDS; i++) hash[i] = rnd_word();
        @(negedge clk_i);
        eng_done_i  = 1'b1;
        eng_hash_i  = hash;
        dig_ready_i = 1'b0;
        #1;
        check("dig_before_done", 64'(dig_valid_o), 64'(0));
        @(negedge clk_i);
        eng_done_i = 1'b0;
        for (int i = 0; i < DIGEST_WORDS; i++) eng_hash_i[i] = rnd_word();
        #1;
        check("dig_latency", 64'(dig_valid_o), 64'(1));

        got        = 0;
        cyc        = 0;
        stalled    = 1'b0;
        stall_left = 0;
        pend       = 1'b1;
        while (got < DIGEST_WORDS && cyc < TMO) begin
            @(negedge clk_i);
            cmd_valid_i  = hold;
            cmd_opcode_i = ~op;
            if (stall && got == 3 && !stalled) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                dig_ready_i = 1'b0;
                stall_left--;
            end else begin
                dig_ready_i = ($urandom_range(0, 2) != 0);
            end
            #1;
            cyc++;
            if (pend) check("dig_hold", 64'(dig_valid_o), 64'(1));
            check("cmd_blocked", 64'({cmd_ready_o, eng_start_o}), 64'(0));
            if (dig_valid_o) check("dig_word", 64'(dig_data_o), 64'(hash[got]));
            if (dig_valid_o && dig_ready_i) begin
                check("dig_last", 64'(dig_last_o), 64'(got == DIGEST_WORDS - 1));
                got++;
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
        end
        if (got != DIGEST_WORDS) check("dig_timeout", 64'(got), 64'(DIGEST_WORDS));

        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        dig_ready_i = 1'b0;
        #1;
        check("idle", 64'({cmd_ready_o, busy_o, dig_valid_o, err_o}), 64'(4'b1000));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int nk;

        vecs[0] = '{4'h0, 3, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{4'h8, 2, 1'b0, 1'b0, 1'b0, 16};
        vecs[2] = '{4'h1, 5, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{4'h9, 1, 1'b0, 1'b1, 1'b0, 16};
        vecs[4] = '{4'hC, 7, 1'b1, 1'b0, 1'b1, 16};
        vecs[5] = '{4'h7, 4, 1'b0, 1'b1, 1'b0, 0};

        aresetn_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_opcode_i = '0;
        key_wr_i = 1'b0; key_idx_i = '0; key_data_i = '0;
        msg_valid_i = 1'b0; msg_data_i = '0; msg_last_i = 1'b0;
        eng_key_ready_i = 1'b0; eng_ready_i = 1'b0; eng_done_i = 1'b0; eng_hash_i = '0;
        dig_ready_i = 1'b0;
        for (int i = 0; i < KEY_WORDS; i++) key_model[i] = '0;

        repeat (3) @(negedge clk_i);
        #1;
        check("reset_outs", 64'({cmd_ready_o, busy_o, eng_start_o, eng_abort_o, eng_data_valid_o,
                                 eng_key_valid_o, dig_valid_o, err_o, msg_ready_o}), 64'(0));
        @(negedge clk_i);
        aresetn_i = 1'b1;
        #1;
        check("ready_at_release", 64'(cmd_ready_o), 64'(0));
        @(negedge clk_i);
        #1;
        check("ready_after_release", 64'(cmd_ready_o), 64'(1));

        program_key(1'b0);
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].new_key) program_key(1'b1);
            do_op(vecs[v].op, vecs[v].nwords, vecs[v].stall, vecs[v].hold, nk);
            check("key_count", 64'(nk), 64'(vecs[v].exp_keys));
        end

        // Protocol error: engine reports done in the middle of the key stream.
        @(negedge clk_i);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = 4'h8;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            eng_key_ready_i = 1'b1;
            #1;
            check("abort_key", 64'(eng_key_o), 64'(key_model[KEY_WORDS - 1 - j]));
        end
        @(negedge clk_i);
        eng_key_ready_i = 1'b0;
        eng_done_i      = 1'b1;
        #1;
        check("abort_pre", 64'({eng_abort_o, err_o}), 64'(2'b00));
        @(negedge clk_i);
        eng_done_i = 1'b0;
        #1;
        check("abort_pulse", 64'({eng_abort_o, busy_o}), 64'(2'b11));
        @(negedge clk_i);
        #1;
        check("abort_done", 64'({eng_abort_o, err_o, cmd_ready_o, busy_o}), 64'(4'b0110));
        @(negedge clk_i);
        #1;
        check("err_sticky", 64'({err_o, eng_abort_o}), 64'(2'b10));
        do_op(4'h2, 2, 1'b0, 1'b0, nk);

        // Reset while waiting for the digest.
        @(negedge clk_i);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = 4'h0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        msg_valid_i = 1'b1; msg_last_i = 1'b1; msg_data_i = rnd_word(); eng_ready_i = 1'b1;
        @(negedge clk_i);
        msg_valid_i = 1'b0; msg_last_i = 1'b0;
        #1;
        check("pre_reset_wait", 64'({busy_o, dig_valid_o}), 64'(2'b10));
        @(negedge clk_i);
        aresetn_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk_i);
            #1;
            check("mid_reset_outs", 64'({cmd_ready_o, busy_o, eng_start_o, eng_abort_o, eng_data_valid_o,
                                         eng_key_valid_o, dig_valid_o, err_o, msg_ready_o}), 64'(0));
        end
        for (int i = 0; i < KEY_WORDS; i++) key_model[i] = '0;
        @(negedge clk_i);
        aresetn_i = 1'b1;
        #1;
        check("no_abort_release", 64'(eng_abort_o), 64'(0));
        @(negedge clk_i);
        #1;
        check("ready_after_reset", 64'({cmd_ready_o, eng_abort_o}), 64'(2'b10));
        do_op(4'h8, 3, 1'b0, 1'b0, nk);
        check("key_count_post_reset", 64'(nk), 64'(16));

        for (int r = 0; r < 8; r++) begin
            logic [3:0] op;
            op = 4'($urandom());
            if ($urandom_range(0, 2) == 0) program_key(1'b1);
            do_op(op, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nk);
            check("rand_key_count", 64'(nk), op[3] ? 64'(16) : 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lw_hmac_host.md
# lw_hmac_host

Host-side initiator for the lightweight SHA/HMAC engine interface. It accepts a command, an optional 16-word HMAC key and a message word stream from the system side. It drives the engine's start/data/key handshakes, collects the 8-word digest on engine done, and returns the digest as a serial word stream. It sits between the bus/DMA front end and the hashing engine wrapper.

## Interface
- WORD_W, 32, data/key/digest word width (64 when CORE_ARCH_S64 is defined)
- KEY_WORDS, 16, key words per HMAC operation
- DIGEST_WORDS, 8, digest words returned
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with LW_HOST_TIMEOUT_EN)
- clk_i  in  1  clock; one clock domain
- aresetn_i  in  1  reset; synchronous, active-low
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_opcode_i  in  4  engine opcode; bit 3 = HMAC
- key_wr_i, key_idx_i[3:0], key_data_i[WORD_W]  in  key register file write port
- msg_valid_i / msg_ready_o  in/out  1  message handshake
- msg_data_i  in  WORD_W  message word; msg_last_i  in  1  final word
- eng_start_o, eng_abort_o, eng_data_valid_o, eng_last_o  out  1  engine controls
- eng_data_o  out  WORD_W; eng_opcode_o  out  4
- eng_key_o  out  WORD_W; eng_key_valid_o  out  1; eng_key_ready_i  in  1
- eng_ready_i, eng_done_i  in  1  engine data ready, digest done
- eng_hash_i  in  DIGEST_WORDS x WORD_W  digest, valid from eng_done_i onward
- dig_valid_o / dig_ready_i  out/in  1  digest stream; dig_data_o  out  WORD_W; dig_last_o  out  1
- busy_o  out  1; err_o  out  1  sticky until next accepted command

## Operation
- FSM states: IDLE, START, KEY, MSG, WAIT, DRAIN, ABORT.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch the opcode and go to START.
- START: one cycle with eng_start_o=1, eng_data_valid_o=1 and eng_opcode_o=latched value. No word is transferred in this cycle. Next state is KEY if opcode[3] is set, otherwise MSG.
- KEY: key index counter starts at 15 and counts down. eng_key_o=key_reg[idx], eng_key_valid_o=1. A word transfers on eng_key_valid_o && eng_key_ready_i. After idx 0 transfers, go to MSG.
- MSG: eng_data_valid_o=msg_valid_i, eng_data_o=msg_data_i, eng_last_o=msg_last_i, msg_ready_o=eng_ready_i. A transfer with last set moves to WAIT.
- WAIT: on eng_done_i, capture eng_hash_i into the digest buffer and go to DRAIN.
- DRAIN: word index 0..7 emits buffer[idx]. dig_last_o is high at idx 7. A transfer with last set returns to IDLE.
- ABORT: eng_abort_o=1 for exactly one cycle, set err_o, go to IDLE.
- eng_done_i seen in KEY or MSG is a protocol error and goes to ABORT.
- A key write in any state other than IDLE is ignored.
- Key words are stored as written; masking with the 0x36/0x5c pads is the engine's job.

## Timing
- Reset values: all outputs 0 except cmd_ready_o=0 during reset and 1 in the first cycle after release. Counters, key file and digest buffer clear to 0.
- Command accept to eng_start_o: 1 cycle.
- Key stream sustains 1 word/cycle while eng_key_ready_i is high.
- Message path is combinational pass-through (zero latency), gated by eng_ready_i.
- Digest: eng_done_i in cycle N gives dig_valid_o in cycle N+1.
- Outputs hold while the downstream ready is low (valid/data stable).
- Simultaneous cmd_valid_i and the final DRAIN transfer: the command is not accepted until IDLE, one cycle later.
- Reset low in mid-operation: return to IDLE next edge; eng_abort_o is not asserted.

## Configuration
- LW_HOST_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in KEY, MSG and WAIT without a transfer or done. It reloads on each handshake. Reaching TIMEOUT_CYC goes to ABORT.
- LW_HOST_TIMEOUT_EN undefined: no watchdog; a stalled engine hangs forever; err_o is driven only by protocol errors.

## Structure
- The shared package lw_sha_pkg holds the host state enum, KEY_WORDS, DIGEST_WORDS and the HMAC opcode bit position.
- Sub-module lw_hmac_host_dig_buf: 8-entry capture register with serialiser, exposing a valid/ready output and a last flag.

## Test plan
- SHA opcode 4'h0, 3 words ending with last -> eng_start_o one cycle; 3 MSG transfers; eng_done_i gives 8 dig words, dig_last_o on the 8th.
- HMAC opcode 4'h8, key[i]=i -> key words presented in order 15..0 before any message word.
- dig_ready_i low for 5 cycles mid-DRAIN -> dig_data_o stable; no words lost or duplicated.
- eng_done_i injected during KEY -> eng_abort_o one cycle; err_o=1; return to IDLE.
- LW_HOST_TIMEOUT_EN, TIMEOUT_CYC=16, eng_ready_i held low -> abort 16 cycles after the last transfer.
- aresetn_i low in WAIT -> IDLE; all outputs 0; the next command completes normally.
